// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with bounded bursts per grant.
// Latency: grant taken on the edge that sees a request; first word written the next cycle; 1 idle bubble between grants.
// Backpressure: fifo_full freezes the grant (count, owner, state) with no write and no timeout; requesters hold req/data until ack.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int BITW      = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*BITW-1:0]      req_data,
    output logic [NREQ-1:0]           ack,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [BITW-1:0]           fifo_din,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    // Count value held while the final word of a burst is being written.
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   burst_q, burst_d;

    logic [IW-1:0]   pick;
    logic            found;
    int              cand_idx;
    logic            any_req;
    logic            own_req;
    logic            xfer;
    logic            release_grant;

    assign any_req = |req;
    assign own_req = req[owner_q];

    // A word moves only when the owner still offers one and the FIFO can take it.
    assign xfer = (state_q == GRANT) & own_req & ~fifo_full;

    // Grant ends after the last burst word, or as soon as the owner has nothing to offer.
    assign release_grant = (state_q == GRANT) &&
                           ((xfer && (burst_q == LAST_CNT)) || !own_req);

    // Rotating-priority scan: first requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        cand_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand_idx = int'(rr_ptr_q) + i;
            if (cand_idx >= NREQ) begin
                cand_idx = cand_idx - NREQ;
            end
            if (!found && req[IW'(cand_idx)]) begin
                pick  = IW'(cand_idx);
                found = 1'b1;
            end
        end
    end

    // Next-state logic: take a grant from IDLE, count words and release from GRANT.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick;
                    burst_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    burst_d = burst_q + CW'(1);
                end
                if (release_grant) begin
                    // Requester after the releasing owner gets top priority next round.
                    rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset back to IDLE and priority 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

    // Write-port steering; everything reads zero outside a grant or while reset is asserted.
    always_comb begin
        ack        = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        owner      = '0;
        busy       = 1'b0;
        if (!reset && (state_q == GRANT)) begin
            busy         = 1'b1;
            owner        = owner_q;
            fifo_din     = req_data[int'(owner_q)*BITW +: BITW];
            fifo_wr_en   = xfer;
            ack[owner_q] = xfer;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [15:0] fifo_din;
    logic [1:0]  owner;
    logic        busy;

    logic        rst1;
    logic [3:0]  req1;
    logic [63:0] data1;
    logic [3:0]  ack1;
    logic        full1;
    logic        wr1;
    logic [15:0] din1;
    logic [1:0]  owner1;
    logic        busy1;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(4), .BITW(16), .MAX_BURST(4)) u_dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .owner(owner), .busy(busy)
    );

    fifo_wr_arbiter #(.NREQ(4), .BITW(16), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .reset(rst1), .req(req1), .req_data(data1), .ack(ack1),
        .fifo_full(full1), .fifo_wr_en(wr1), .fifo_din(din1),
        .owner(owner1), .busy(busy1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the port, how many words it sent, who is first in line.
    int          m_holder = -1;
    int          m_sent   = 0;
    int          m_prio   = 0;
    localparam int MB = 4;

    // Producers: pending flag and current word per requester.
    logic [3:0]  preq;
    logic [15:0] pdata [4];
    bit          rand_mode = 1'b0;

    typedef struct {
        bit          rst;
        logic [3:0]  rq;
        logic        exp_wr;
        logic [3:0]  exp_ack;
        logic [15:0] exp_din;
        logic [1:0]  exp_own;
        logic        exp_busy;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string name, input int cyc_i, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_i, act, exp);
        end
    endtask

    // One clock of the main DUT: drive, sample, compare with the model, advance model and producers.
    task automatic cyc(input bit rst, input bit full,
                       output logic [3:0] a_ack, output logic a_wr, output logic [15:0] a_din,
                       output logic [1:0] a_own, output logic a_busy);
        logic [3:0]  e_ack;
        logic        e_wr;
        logic [15:0] e_din;
        logic [1:0]  e_own;
        logic        e_busy;
        bit          x;
        bit          got;
        int          c;
        reset     = rst;
        fifo_full = full;
        req       = preq;
        for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = pdata[i];
        #2;
        a_ack = ack; a_wr = fifo_wr_en; a_din = fifo_din; a_own = owner; a_busy = busy;

        e_ack = '0; e_wr = 1'b0; e_din = '0; e_own = '0; e_busy = 1'b0; x = 1'b0;
        if (!rst && m_holder >= 0) begin
            e_busy = 1'b1;
            e_own  = m_holder[1:0];
            e_din  = pdata[m_holder];
            x      = preq[m_holder] && !full;
            e_wr   = x;
            if (x) e_ack[m_holder] = 1'b1;
        end
        chk("model_outs", total, 64'({a_ack, a_wr, a_din, a_own, a_busy}),
            64'({e_ack, e_wr, e_din, e_own, e_busy}));

        if (rst) begin
            m_holder = -1; m_sent = 0; m_prio = 0;
        end else if (m_holder < 0) begin
            got = 1'b0;
            for (int k = 0; k < 4; k++) begin
                c = (m_prio + k) % 4;
                if (!got && preq[c]) begin
                    m_holder = c; got = 1'b1;
                end
            end
            m_sent = 0;
        end else begin
            if (x) m_sent++;
            if ((x && m_sent == MB) || !preq[m_holder]) begin
                m_prio   = (m_holder + 1) % 4;
                m_holder = -1;
            end
        end

        for (int i = 0; i < 4; i++) begin
            if (e_ack[i]) begin
                pdata[i] = rand_mode ? 16'($urandom) : pdata[i] + 16'd1;
                if (rand_mode) preq[i] = ($urandom % 4) != 0;
            end else if (rand_mode && !preq[i]) begin
                preq[i] = ($urandom % 3) == 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  a_ack;
        logic        a_wr;
        logic [15:0] a_din;
        logic [1:0]  a_own;
        logic        a_busy;
        logic [8:0]  wexp3, bexp3, full3;
        logic [1:0]  eo;

        reset = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
        rst1 = 1'b1; req1 = '0; data1 = '0; full1 = 1'b0;
        preq = '0;
        for (int i = 0; i < 4; i++) pdata[i] = 16'(16'h10 * i);
        pdata[1] = 16'hA0;

        tv[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 16'h0000, 2'd0, 1'b0};
        tv[1]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 16'h0000, 2'd0, 1'b0};
        tv[2]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 16'h00A0, 2'd1, 1'b1};
        tv[3]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 16'h00A1, 2'd1, 1'b1};
        tv[4]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 16'h00A2, 2'd1, 1'b1};
        tv[5]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 16'h00A3, 2'd1, 1'b1};
        tv[6]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 16'h0000, 2'd0, 1'b0};
        tv[7]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 16'h00A4, 2'd1, 1'b1};
        tv[8]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 16'h00A5, 2'd1, 1'b1};
        tv[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 16'h00A6, 2'd1, 1'b1};
        tv[10] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 16'h0000, 2'd0, 1'b0};

        @(posedge clk);
        #1;

        // Single requester: burst of 4, bubble, remaining 2 words, release on req drop.
        for (int k = 0; k < 11; k++) begin
            preq = tv[k].rq;
            cyc(tv[k].rst, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
            chk("single_req_table", k, 64'({a_wr, a_ack, a_din, a_own, a_busy}),
                64'({tv[k].exp_wr, tv[k].exp_ack, tv[k].exp_din, tv[k].exp_own, tv[k].exp_busy}));
        end

        // All four requesting: owners 0,1,2,3,0 with 4 words each and a bubble between.
        preq = '0;
        cyc(1'b1, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
        preq = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            cyc(1'b0, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
            eo = 2'((c / 5) % 4);
            if (c % 5 == 0) chk("rr_bubble", c, 64'({a_wr, a_ack}), 64'(0));
            else            chk("rr_owner", c, 64'({a_wr, a_ack, a_own}), 64'({1'b1, 4'(1 << eo), eo}));
        end

        // Owner 2 stalled by fifo_full for 3 cycles after 2 words.
        preq = '0;
        cyc(1'b1, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
        preq  = 4'b0100;
        wexp3 = 9'b011000110;
        bexp3 = 9'b011111110;
        full3 = 9'b000111000;
        for (int c = 0; c < 9; c++) begin
            cyc(1'b0, full3[c], a_ack, a_wr, a_din, a_own, a_busy);
            chk("full_stall", c, 64'({a_wr, a_busy, a_own, a_ack}),
                64'({wexp3[c], bexp3[c], bexp3[c] ? 2'd2 : 2'd0, wexp3[c] ? 4'b0100 : 4'b0000}));
        end

        // Owner 0 drops req after 2 words; next owners 2, 3, 0.
        preq = '0;
        cyc(1'b1, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
        preq = 4'b1101;
        for (int c = 0; c < 16; c++) begin
            if (c == 3) preq[0] = 1'b0;
            if (c == 4) preq[0] = 1'b1;
            cyc(1'b0, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
            if (c == 3)  chk("drop_release", c, 64'({a_busy, a_wr, a_own}), 64'({1'b1, 1'b0, 2'd0}));
            if (c == 4)  chk("drop_bubble", c, 64'({a_busy, a_wr}), 64'(0));
            if (c == 5)  chk("drop_next2", c, 64'({a_wr, a_own}), 64'({1'b1, 2'd2}));
            if (c == 10) chk("drop_next3", c, 64'({a_wr, a_own}), 64'({1'b1, 2'd3}));
            if (c == 15) chk("drop_next0", c, 64'({a_wr, a_own}), 64'({1'b1, 2'd0}));
        end

        // Reset in the middle of owner 3's burst with req[0] pending.
        preq = '0;
        cyc(1'b1, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
        preq = 4'b1000;
        cyc(1'b0, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
        cyc(1'b0, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
        chk("rst_pre_w3", 1, 64'({a_wr, a_own}), 64'({1'b1, 2'd3}));
        preq[0] = 1'b1;
        cyc(1'b0, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
        chk("rst_pre_w3b", 2, 64'({a_wr, a_own, a_ack}), 64'({1'b1, 2'd3, 4'b1000}));
        cyc(1'b1, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
        chk("rst_mid", 3, 64'({a_wr, a_busy, a_own, a_ack, a_din}), 64'(0));
        cyc(1'b0, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
        chk("rst_idle", 4, 64'({a_busy, a_wr}), 64'(0));
        cyc(1'b0, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
        chk("rst_first0", 5, 64'({a_wr, a_busy, a_own, a_ack}), 64'({1'b1, 1'b1, 2'd0, 4'b0001}));

        // Randomized traffic, stalls and occasional resets against the model.
        rand_mode = 1'b1;
        preq = '0;
        cyc(1'b1, 1'b0, a_ack, a_wr, a_din, a_own, a_busy);
        for (int c = 0; c < 3000; c++) begin
            cyc(($urandom % 250) == 0, ($urandom % 5) == 0, a_ack, a_wr, a_din, a_own, a_busy);
        end

        // MAX_BURST = 1: writes alternate 0,1,0,1 with a bubble between each.
        data1 = {16'h0000, 16'h0000, 16'h00B1, 16'h00B0};
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        req1 = 4'b0011;
        for (int c = 0; c < 9; c++) begin
            #2;
            eo = 2'(((c - 1) / 2) % 2);
            if (c % 2 == 0) chk("mb1_bubble", c, 64'({wr1, ack1, busy1}), 64'(0));
            else chk("mb1_write", c, 64'({wr1, ack1, owner1, din1}),
                     64'({1'b1, 4'(1 << eo), eo, (eo == 2'd0) ? 16'h00B0 : 16'h00B1}));
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
